// File: rtl/uart_sink.sv
// Receive-side byte sink: FIFO buffer with valid/ready drain, line framing on TERM,
// running byte sum and sticky error flags. Optional CRC-8 per line under UART_SINK_CRC_EN.
module uart_sink #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  TERM       = 8'h0A,
  parameter int          MAX_LEN    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    i_data,
  input  logic                          i_valid,
  input  logic                          i_ready,
  output logic [7:0]                    o_data,
  output logic                          o_valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_line,
  output logic [7:0]                    o_len,
  output logic [31:0]                   o_sum,
  output logic                          o_overflow,
  output logic                          o_toolong,
  output logic [7:0]                    o_crc
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_LINE, S_SKIP} state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full, push, pop, is_term;

  state_t        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    o_len_q, o_len_d;
  logic          line_q, line_d;
  logic          toolong_q, toolong_d;
  logic          overflow_q;
  logic [31:0]   sum_q;

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign o_valid = (count_q != '0);
  assign pop     = o_valid && i_ready;
  assign push    = i_valid && (!full || pop);
  assign is_term = (i_data == TERM);

  // NOTE: storage array has no reset; emptiness is tracked by count_q, and o_data is
  // gated so it reads 0 while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_data = o_valid ? mem_q[rd_ptr_q] : 8'h00;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      sum_q      <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (i_valid && !push) overflow_q <= 1'b1;
      if (push) sum_q <= sum_q + 32'(i_data);
    end
  end

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    o_len_d   = o_len_q;
    line_d    = 1'b0;
    toolong_d = toolong_q;
    if (push) begin
      case (state_q)
        S_IDLE: begin
          if (is_term) begin
            line_d  = 1'b1;
            o_len_d = 8'd1;
          end else begin
            len_d   = 8'd1;
            state_d = S_LINE;
          end
        end
        S_LINE: begin
          if (is_term) begin
            line_d  = 1'b1;
            o_len_d = len_q + 8'd1;
            state_d = S_IDLE;
          end else if (len_q + 8'd1 == 8'(MAX_LEN)) begin
            toolong_d = 1'b1;
            state_d   = S_SKIP;
          end else begin
            len_d = len_q + 8'd1;
          end
        end
        S_SKIP: begin
          if (is_term) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      o_len_q   <= '0;
      line_q    <= 1'b0;
      toolong_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      o_len_q   <= o_len_d;
      line_q    <= line_d;
      toolong_q <= toolong_d;
    end
  end

`ifdef UART_SINK_CRC_EN
  // CRC-8, poly 0x07, MSB first, no reflection, no final xor.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  logic [7:0] crc_run_q, crc_out_q;

  // TERM restarts the running CRC, which also covers leaving S_SKIP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_run_q <= 8'h00;
      crc_out_q <= 8'h00;
    end else begin
      if (push) crc_run_q <= is_term ? 8'h00 : crc8_step(crc_run_q, i_data);
      if (line_d) crc_out_q <= crc_run_q;
    end
  end

  assign o_crc = crc_out_q;
`else
  assign o_crc = 8'h00;
`endif

  assign o_count    = count_q;
  assign o_line     = line_q;
  assign o_len      = o_len_q;
  assign o_sum      = sum_q;
  assign o_overflow = overflow_q;
  assign o_toolong  = toolong_q;

endmodule

// File: tb/tb_uart_sink.sv
// Directed bench for uart_sink: FIFO order/latency, overflow, full push+pop,
// line framing incl. MAX_LEN boundary, CRC line result, asynchronous reset.
module tb_uart_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_data;
  logic        i_valid;
  logic        i_ready;
  logic [7:0]  o_data;
  logic        o_valid;
  logic [4:0]  o_count;
  logic        o_line;
  logic [7:0]  o_len;
  logic [31:0] o_sum;
  logic        o_overflow;
  logic        o_toolong;
  logic [7:0]  o_crc;

  int passed = 0;
  int total  = 0;
  int line_pulses = 0;

`ifdef UART_SINK_CRC_EN
  localparam logic [7:0] EXP_CRC_A   = 8'hC0;
  localparam logic [7:0] EXP_CRC_NUM = 8'hF4;
`else
  localparam logic [7:0] EXP_CRC_A   = 8'h00;
  localparam logic [7:0] EXP_CRC_NUM = 8'h00;
`endif

  uart_sink #(.FIFO_DEPTH(16), .TERM(8'h0A), .MAX_LEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_count    (o_count),
    .o_line     (o_line),
    .o_len      (o_len),
    .o_sum      (o_sum),
    .o_overflow (o_overflow),
    .o_toolong  (o_toolong),
    .o_crc      (o_crc)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (o_line) line_pulses++;
  endtask

  task automatic send(input logic [7:0] b);
    i_data  = b;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    line_pulses = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_data = 8'h00; i_valid = 1'b0; i_ready = 1'b0;
    #2;
    if ({o_valid, o_count, o_line, o_len, o_overflow, o_toolong, o_data, o_crc} !== '0) begin
      $display("FAIL reset_outputs: got v=%b cnt=%0d line=%b len=%0d ovf=%b tl=%b data=%h crc=%h exp all 0",
               o_valid, o_count, o_line, o_len, o_overflow, o_toolong, o_data, o_crc);
    end else passed++;
    total++;
    if (o_sum !== 32'h0) $display("FAIL reset_sum: got %h exp 0", o_sum); else passed++;
    total++;
    tick(); tick();
    rst = 1'b0;
    tick();
    if (o_valid !== 1'b0 || o_count !== 5'd0) begin
      $display("FAIL reset_idle: got v=%b cnt=%0d exp 0/0", o_valid, o_count);
    end else passed++;
    total++;
  endtask

  task automatic test_hello();
    logic [7:0] msg [6];
    msg = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0A};
    do_reset();
    i_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      send(msg[k]);
      if (o_valid !== 1'b1 || o_data !== msg[k] || o_count !== 5'd1) begin
        $display("FAIL hello_fifo[%0d]: got v=%b data=%h cnt=%0d exp 1/%h/1", k, o_valid, o_data, o_count, msg[k]);
      end else passed++;
      total++;
    end
    if (o_line !== 1'b1 || o_len !== 8'd6) begin
      $display("FAIL hello_line: got line=%b len=%0d exp 1/6", o_line, o_len);
    end else passed++;
    total++;
    if (o_sum !== 32'h17E) $display("FAIL hello_sum: got %h exp 17e", o_sum); else passed++;
    total++;
    tick();
    if (o_line !== 1'b0 || o_count !== 5'd0 || line_pulses != 1) begin
      $display("FAIL hello_after: got line=%b cnt=%0d pulses=%0d exp 0/0/1", o_line, o_count, line_pulses);
    end else passed++;
    total++;
    i_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    i_ready = 1'b0;
    for (int k = 1; k <= 16; k++) send(8'(k));
    if (o_count !== 5'd16 || o_overflow !== 1'b0) begin
      $display("FAIL ovf_fill: got cnt=%0d ovf=%b exp 16/0", o_count, o_overflow);
    end else passed++;
    total++;
    send(8'h11);
    if (o_count !== 5'd16 || o_overflow !== 1'b1) begin
      $display("FAIL ovf_drop: got cnt=%0d ovf=%b exp 16/1", o_count, o_overflow);
    end else passed++;
    total++;
    if (o_sum !== 32'h88) $display("FAIL ovf_sum: got %h exp 88", o_sum); else passed++;
    total++;
    if (o_len !== 8'd10) $display("FAIL ovf_len: got %0d exp 10", o_len); else passed++;
    total++;
    i_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      if (o_data !== 8'(k) || o_valid !== 1'b1) begin
        $display("FAIL ovf_drain[%0d]: got v=%b data=%h exp 1/%h", k, o_valid, o_data, 8'(k));
      end else passed++;
      total++;
      tick();
    end
    if (o_count !== 5'd0 || o_valid !== 1'b0 || o_overflow !== 1'b1) begin
      $display("FAIL ovf_empty: got cnt=%0d v=%b ovf=%b exp 0/0/1", o_count, o_valid, o_overflow);
    end else passed++;
    total++;
    i_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    i_ready = 1'b0;
    for (int k = 0; k < 16; k++) send(8'h30 + 8'(k));
    i_ready = 1'b1;
    send(8'h40);
    i_ready = 1'b0;
    if (o_count !== 5'd16 || o_overflow !== 1'b0) begin
      $display("FAIL full_pp: got cnt=%0d ovf=%b exp 16/0", o_count, o_overflow);
    end else passed++;
    total++;
    if (o_data !== 8'h31 || o_sum !== 32'h3B8) begin
      $display("FAIL full_pp_data: got data=%h sum=%h exp 31/3b8", o_data, o_sum);
    end else passed++;
    total++;
  endtask

  task automatic test_toolong();
    do_reset();
    i_ready = 1'b1;
    for (int k = 0; k < 63; k++) send(8'h42);
    send(8'h0A);
    if (o_line !== 1'b1 || o_len !== 8'd64 || o_toolong !== 1'b0) begin
      $display("FAIL maxlen_ok: got line=%b len=%0d tl=%b exp 1/64/0", o_line, o_len, o_toolong);
    end else passed++;
    total++;
    line_pulses = 0;
    for (int k = 0; k < 63; k++) send(8'h41);
    if (o_toolong !== 1'b0) $display("FAIL toolong_early: got %b exp 0", o_toolong); else passed++;
    total++;
    send(8'h41);
    if (o_toolong !== 1'b1) $display("FAIL toolong_set: got %b exp 1", o_toolong); else passed++;
    total++;
    for (int k = 0; k < 6; k++) send(8'h41);
    send(8'h0A);
    tick();
    if (line_pulses != 0 || o_len !== 8'd64) begin
      $display("FAIL toolong_nopulse: got pulses=%0d len=%0d exp 0/64", line_pulses, o_len);
    end else passed++;
    total++;
    send(8'h41);
    send(8'h0A);
    if (o_line !== 1'b1 || o_len !== 8'd2 || o_toolong !== 1'b1 || o_crc !== EXP_CRC_A) begin
      $display("FAIL toolong_next: got line=%b len=%0d tl=%b crc=%h exp 1/2/1/%h",
               o_line, o_len, o_toolong, o_crc, EXP_CRC_A);
    end else passed++;
    total++;
    i_ready = 1'b0;
  endtask

  task automatic test_crc();
    do_reset();
    i_ready = 1'b1;
    send(8'h0A);
    if (o_line !== 1'b1 || o_len !== 8'd1 || o_crc !== 8'h00) begin
      $display("FAIL empty_line: got line=%b len=%0d crc=%h exp 1/1/00", o_line, o_len, o_crc);
    end else passed++;
    total++;
    for (int k = 1; k <= 9; k++) send(8'h30 + 8'(k));
    send(8'h0A);
    if (o_line !== 1'b1 || o_len !== 8'd10 || o_crc !== EXP_CRC_NUM) begin
      $display("FAIL crc_line: got line=%b len=%0d crc=%h exp 1/10/%h", o_line, o_len, o_crc, EXP_CRC_NUM);
    end else passed++;
    total++;
    i_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++) send(8'h61 + 8'(k));
    if (o_count !== 5'd5) $display("FAIL arst_pre: got cnt=%0d exp 5", o_count); else passed++;
    total++;
    #2 rst = 1'b1;
    #1;
    if (o_valid !== 1'b0 || o_count !== 5'd0 || o_sum !== 32'h0) begin
      $display("FAIL arst_now: got v=%b cnt=%0d sum=%h exp 0/0/0", o_valid, o_count, o_sum);
    end else passed++;
    total++;
    #1 rst = 1'b0;
    tick();
    if (o_valid !== 1'b0 || o_count !== 5'd0) begin
      $display("FAIL arst_after: got v=%b cnt=%0d exp 0/0", o_valid, o_count);
    end else passed++;
    total++;
  endtask

  initial begin
    test_reset();
    test_hello();
    test_overflow();
    test_full_push_pop();
    test_toolong();
    test_crc();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
